tq_qp_divmod: RTL and testbench

- Sequential, parametrised QP divide/modulo unit for the transform/quant path.
- Applies a signed QP offset (e.g. chroma offset), clamps the result to [0, QP_MAX], then computes qp/DIV and qp%DIV.
- Uses a restoring serial divider that produces one quotient bit per cycle, with valid/ready handshakes on both sides.
- Output feeds the quant scale-table index (mod) and the shift-amount logic (div).

---
 rtl/tq_pkg.sv | 23 ++
 rtl/tq_qp_divmod_if.sv | 28 ++
 rtl/tq_qp_clamp.sv | 23 ++
 rtl/tq_qp_divmod.sv | 139 +++++++++++++
 tb/tb_tq_qp_divmod.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/tq_pkg.sv
// Shared types, codec constants and the QP clamp helper for the transform/quant path.
package tq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } tq_state_e;

    localparam int QP_MAX_HEVC = 51;
    localparam int QP_DIV      = 6;

    // Saturates an offset-adjusted QP into [0, max].
    function automatic int qp_clamp(input int sum, input int max);
        if (sum < 0)
            return 0;
        else if (sum > max)
            return max;
        else
            return sum;
    endfunction

endpackage

// File: rtl/tq_qp_divmod_if.sv
// Request/result handshake bundle for the QP divide/modulo unit.
interface tq_qp_divmod_if #(
    parameter int QP_W   = 6,
    parameter int OFS_W  = 5,
    parameter int QOUT_W = 4,
    parameter int ROUT_W = 3
);
    logic                     flush_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [QP_W-1:0]          qp_i;
    logic signed [OFS_W-1:0]  qp_ofs_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [QOUT_W-1:0]        div_o;
    logic [ROUT_W-1:0]        mod_o;
    logic                     clamp_o;

    modport master (
        output flush_i, in_valid_i, qp_i, qp_ofs_i, out_ready_i,
        input  in_ready_o, out_valid_o, div_o, mod_o, clamp_o
    );

    modport slave (
        input  flush_i, in_valid_i, qp_i, qp_ofs_i, out_ready_i,
        output in_ready_o, out_valid_o, div_o, mod_o, clamp_o
    );
endinterface

// File: rtl/tq_qp_clamp.sv
// Combinational QP + signed offset with saturation to [0, QP_MAX]; also used by dequant.
module tq_qp_clamp
    import tq_pkg::*;
#(
    parameter int QP_W   = 6,
    parameter int OFS_W  = 5,
    parameter int QP_MAX = QP_MAX_HEVC
) (
    input  logic [QP_W-1:0]         qp,
    input  logic signed [OFS_W-1:0] qp_ofs,
    output logic [QP_W-1:0]         qp_clamped,
    output logic                    clamped
);
    logic signed [QP_W+1:0] sum;
    int                     qp_c;

    always_comb begin
        sum        = $signed({2'b00, qp}) + $signed({{(QP_W+2-OFS_W){qp_ofs[OFS_W-1]}}, qp_ofs});
        qp_c       = qp_clamp(int'(sum), QP_MAX);
        qp_clamped = QP_W'(qp_c);
        clamped    = (qp_c != int'(sum));
    end
endmodule

// File: rtl/tq_qp_divmod.sv
// Serial restoring divider producing clamped_qp / DIV and clamped_qp % DIV, one quotient bit per cycle.
module tq_qp_divmod
    import tq_pkg::*;
#(
    parameter int QP_W   = 6,
    parameter int OFS_W  = 5,
    parameter int DIV    = QP_DIV,
    parameter int QP_MAX = QP_MAX_HEVC,
    parameter int QOUT_W = 4,
    parameter int ROUT_W = $clog2(DIV)
) (
    input  logic           clk,
    input  logic           rst,
    tq_qp_divmod_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_CALC = 2'(ST_CALC);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);
    localparam int CNT_W = (QP_W > 1) ? $clog2(QP_W) : 1;
    localparam int REM_W = ROUT_W + 1;
    localparam int R_W   = ROUT_W + 2;

    if (DIV < 2 || DIV >= (1 << QP_W)) begin : g_bad_div
        $error("tq_qp_divmod: DIV must satisfy 2 <= DIV < 2**QP_W");
    end
    if (QP_MAX >= (1 << QP_W)) begin : g_bad_max
        $error("tq_qp_divmod: QP_MAX must be below 2**QP_W");
    end
    if ((QP_MAX / DIV) >= (1 << QOUT_W)) begin : g_bad_qout
        $error("tq_qp_divmod: QOUT_W too narrow for QP_MAX/DIV");
    end
    if (OFS_W > QP_W + 2) begin : g_bad_ofs
        $error("tq_qp_divmod: OFS_W must not exceed QP_W+2");
    end

    logic [1:0]         state;
    logic [QP_W-1:0]    dividend;
    logic [REM_W-1:0]   rem;
    logic [QP_W-1:0]    quo;
    logic [CNT_W-1:0]   cnt;
    logic               clamp_flag;
    logic               out_valid;
    logic [QOUT_W-1:0]  div_q;
    logic [ROUT_W-1:0]  mod_q;
    logic               clamp_q;

    logic [QP_W-1:0]    qp_clamped;
    logic               clamp_hit;
    logic [R_W-1:0]     r;
    logic [REM_W-1:0]   rem_nxt;
    logic [QP_W-1:0]    quo_nxt;

    tq_qp_clamp #(
        .QP_W   (QP_W),
        .OFS_W  (OFS_W),
        .QP_MAX (QP_MAX)
    ) u_clamp (
        .qp         (bus.qp_i),
        .qp_ofs     (bus.qp_ofs_i),
        .qp_clamped (qp_clamped),
        .clamped    (clamp_hit)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r       = {rem, dividend[cnt]};
        quo_nxt = quo;
        if (r >= R_W'(DIV)) begin
            rem_nxt      = REM_W'(r - R_W'(DIV));
            quo_nxt[cnt] = 1'b1;
        end else begin
            rem_nxt      = r[REM_W-1:0];
            quo_nxt[cnt] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            dividend   <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            clamp_flag <= 1'b0;
            out_valid  <= 1'b0;
            div_q      <= '0;
            mod_q      <= '0;
            clamp_q    <= 1'b0;
        end else if (bus.flush_i) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        dividend   <= qp_clamped;
                        clamp_flag <= clamp_hit;
                        rem        <= '0;
                        quo        <= '0;
                        cnt        <= CNT_W'(QP_W - 1);
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt == '0) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        div_q     <= QOUT_W'(quo_nxt);
                        mod_q     <= ROUT_W'(rem_nxt);
                        clamp_q   <= clamp_flag;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state == S_IDLE);
    assign bus.out_valid_o = out_valid;
    assign bus.div_o       = div_q;
    assign bus.mod_o       = mod_q;
    assign bus.clamp_o     = clamp_q;

    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !bus.out_ready_i && !bus.flush_i) |=> out_valid);

    a_divmod_consistent: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (int'(div_q) * DIV + int'(mod_q) == int'(dividend)));
endmodule

// File: tb/tb_tq_qp_divmod.sv
// Directed bench for tq_qp_divmod: sweep, clamping, backpressure, back-to-back, flush and async reset.
module tb_tq_qp_divmod;
    localparam int QP_W   = 6;
    localparam int OFS_W  = 5;
    localparam int QOUT_W = 4;
    localparam int ROUT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    logic saw_valid = 1'b0;

    tq_qp_divmod_if #(.QP_W(QP_W), .OFS_W(OFS_W), .QOUT_W(QOUT_W), .ROUT_W(ROUT_W)) bus ();

    tq_qp_divmod #(
        .QP_W   (QP_W),
        .OFS_W  (OFS_W),
        .DIV    (6),
        .QP_MAX (51),
        .QOUT_W (QOUT_W),
        .ROUT_W (ROUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && !bus.flush_i && bus.in_valid_i && bus.in_ready_o) begin
            prev_acc = last_acc;
            last_acc = cyc;
        end
        if (bus.out_valid_o === 1'b1)
            saw_valid = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic request(input int qp, input int ofs);
        bus.qp_i       = QP_W'(qp);
        bus.qp_ofs_i   = OFS_W'(ofs);
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic txn(input string tag, input int qp, input int ofs,
                       input int ed, input int em, input int ec);
        int n;
        request(qp, ofs);
        wait_valid(n);
        check({tag, "_lat"}, n, 6);
        check({tag, "_div"}, bus.div_o, ed);
        check({tag, "_mod"}, bus.mod_o, em);
        check({tag, "_clamp"}, bus.clamp_o, ec);
        step();
    endtask

    initial begin
        int n;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.qp_i        = '0;
        bus.qp_ofs_i    = '0;
        bus.out_ready_i = 1'b1;

        // Reset state
        #12;
        check("rst_valid", bus.out_valid_o, 0);
        check("rst_outs", {bus.div_o, bus.mod_o, bus.clamp_o}, 0);
        rst = 1'b0;
        step();
        check("rst_ready", bus.in_ready_o, 1);

        // Full sweep without offset
        for (int q = 0; q <= 51; q++)
            txn($sformatf("sweep%0d", q), q, 0, q / 6, q % 6, 0);

        // Clamping
        txn("clamp_lo", 2, -5, 0, 0, 1);
        txn("clamp_hi", 45, 12, 8, 3, 1);
        txn("exact_max", 40, 11, 8, 3, 0);

        // Backpressure
        bus.out_ready_i = 1'b0;
        request(37, 0);
        wait_valid(n);
        check("bp_lat", n, 6);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i),
                  {bus.out_valid_o, bus.in_ready_o, bus.div_o, bus.mod_o}, {1'b1, 1'b0, 4'd6, 3'd1});
            step();
        end
        bus.out_ready_i = 1'b1;
        step();
        check("bp_release", {bus.out_valid_o, bus.in_ready_o}, {1'b0, 1'b1});
        check("bp_div_hold", bus.div_o, 6);

        // Back-to-back with in_valid held
        bus.qp_i       = 6'd12;
        bus.qp_ofs_i   = '0;
        bus.in_valid_i = 1'b1;
        step();
        bus.qp_i = 6'd17;
        wait_valid(n);
        check("b2b0_div", bus.div_o, 2);
        check("b2b0_mod", bus.mod_o, 0);
        step();
        step();
        bus.in_valid_i = 1'b0;
        check("b2b_spacing", last_acc - prev_acc, 8);
        wait_valid(n);
        check("b2b1_div", bus.div_o, 2);
        check("b2b1_mod", bus.mod_o, 5);
        step();

        // Flush in IDLE blocks a simultaneous request
        saw_valid      = 1'b0;
        bus.qp_i       = 6'd7;
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        check("flush_idle_ready", bus.in_ready_o, 1);
        for (int i = 0; i < 8; i++) step();
        check("flush_idle_novalid", saw_valid, 0);

        // Flush on the 3rd CALC cycle
        request(50, 0);
        step();
        step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("flush_ready", bus.in_ready_o, 1);
        for (int i = 0; i < 10; i++) step();
        check("flush_novalid", saw_valid, 0);
        txn("after_flush", 23, 0, 3, 5, 0);

        // Asynchronous reset in DONE
        bus.out_ready_i = 1'b0;
        request(9, 0);
        wait_valid(n);
        check("ar_div", bus.div_o, 1);
        check("ar_mod", bus.mod_o, 3);
        #1;
        rst = 1'b1;
        #1;
        check("ar_valid", bus.out_valid_o, 0);
        check("ar_outs", {bus.div_o, bus.mod_o, bus.clamp_o}, 0);
        #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        check("ar_idle", {bus.in_ready_o, bus.out_valid_o}, {1'b1, 1'b0});
        txn("after_rst", 51, 0, 8, 3, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
